// File: rtl/hippo_mem_arbiter.sv
// Two-port arbiter in front of the byte-lane data memory: instruction fetch (A)
// and load/store (B) share one port, with a bounded read-modify-write lock for B.
module hippo_mem_arbiter #(
  parameter int MEMORY_DEPTH_BYTES = 1024,
  parameter int FIXED_PRIORITY     = 0,
  parameter int LOCK_MAX_CYCLES    = 8,
  localparam int AddrWidth         = $clog2(MEMORY_DEPTH_BYTES)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,

  input  logic                 a_req_i,
  input  logic [AddrWidth-1:0] a_addr_i,
  input  logic [1:0]           a_width_i,
  input  logic                 a_sign_extend_i,
  input  logic                 a_we_i,
  input  logic [31:0]          a_data_i,
  output logic                 a_gnt_o,
  output logic                 a_rvalid_o,
  output logic [31:0]          a_rdata_o,

  input  logic                 b_req_i,
  input  logic [AddrWidth-1:0] b_addr_i,
  input  logic [1:0]           b_width_i,
  input  logic                 b_sign_extend_i,
  input  logic                 b_we_i,
  input  logic [31:0]          b_data_i,
  input  logic                 b_lock_i,
  output logic                 b_gnt_o,
  output logic                 b_rvalid_o,
  output logic [31:0]          b_rdata_o,

  output logic [AddrWidth-1:0] mem_addr_o,
  output logic [1:0]           mem_width_o,
  output logic                 mem_sign_extend_o,
  output logic [31:0]          mem_data_o,
  output logic                 mem_we_o,
  input  logic [31:0]          mem_data_i
);

  localparam int CntWidth = $clog2(LOCK_MAX_CYCLES + 1);

  typedef enum logic {
    ST_ARB    = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  state_e              state_q;
  logic                prio_q;      // 0 = A favoured, 1 = B favoured
  logic [CntWidth-1:0] lock_cnt_q;
  logic [CntWidth-1:0] lock_cnt_d;
  logic                a_valid_q;
  logic                b_valid_q;
  logic                a_gnt;
  logic                b_gnt;

  // Grant decision; reset masks everything so no access can slip through.
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (!rst_i) begin
      if (state_q == ST_LOCKED) begin
        b_gnt = b_req_i;
      end else if (a_req_i && b_req_i) begin
        if (FIXED_PRIORITY != 0 || prio_q) begin
          b_gnt = 1'b1;
        end else begin
          a_gnt = 1'b1;
        end
      end else begin
        a_gnt = a_req_i;
        b_gnt = b_req_i;
      end
    end
  end

  assign a_gnt_o = a_gnt;
  assign b_gnt_o = b_gnt;

  always_comb begin
    mem_addr_o        = '0;
    mem_width_o       = '0;
    mem_sign_extend_o = 1'b0;
    mem_data_o        = '0;
    mem_we_o          = 1'b0;
    if (a_gnt) begin
      mem_addr_o        = a_addr_i;
      mem_width_o       = a_width_i;
      mem_sign_extend_o = a_sign_extend_i;
      mem_data_o        = a_data_i;
      mem_we_o          = a_we_i;
    end else if (b_gnt) begin
      mem_addr_o        = b_addr_i;
      mem_width_o       = b_width_i;
      mem_sign_extend_o = b_sign_extend_i;
      mem_data_o        = b_data_i;
      mem_we_o          = b_we_i;
    end
  end

  assign lock_cnt_d = lock_cnt_q + CntWidth'(1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_ARB;
      prio_q     <= 1'b0;
      lock_cnt_q <= '0;
      a_valid_q  <= 1'b0;
      b_valid_q  <= 1'b0;
    end else begin
      a_valid_q <= a_gnt;
      b_valid_q <= b_gnt;
      case (state_q)
        ST_ARB: begin
          if (a_gnt) begin
            prio_q <= 1'b1;
          end
          if (b_gnt) begin
            prio_q <= 1'b0;
            // A one-cycle lock budget is exhausted by the entry grant itself.
            if (b_lock_i && LOCK_MAX_CYCLES > 1) begin
              state_q    <= ST_LOCKED;
              lock_cnt_q <= CntWidth'(1);
            end
          end
        end
        ST_LOCKED: begin
          if (!b_req_i) begin
            state_q    <= ST_ARB;
            lock_cnt_q <= '0;
          end else if (!b_lock_i || lock_cnt_d >= CntWidth'(LOCK_MAX_CYCLES)) begin
            state_q    <= ST_ARB;
            lock_cnt_q <= '0;
            prio_q     <= 1'b0;
          end else begin
            lock_cnt_q <= lock_cnt_d;
          end
        end
        default: begin
          state_q <= ST_ARB;
        end
      endcase
    end
  end

  // A response landing in a reset cycle is dropped.
  assign a_rvalid_o = a_valid_q & ~rst_i;
  assign b_rvalid_o = b_valid_q & ~rst_i;
  assign a_rdata_o  = a_rvalid_o ? mem_data_i : 32'h0;
  assign b_rdata_o  = b_rvalid_o ? mem_data_i : 32'h0;

endmodule

// File: tb/tb_hippo_mem_arbiter.sv
// Bench for hippo_mem_arbiter: round-robin instance with a byte memory model,
// plus a fixed-priority instance for the tie-break scenario.
module tb_hippo_mem_arbiter;

  localparam logic [1:0] W_BYTE = 2'd0;
  localparam logic [1:0] W_HALF = 2'd1;
  localparam logic [1:0] W_WORD = 2'd2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_req = 1'b0, a_sx = 1'b0, a_we = 1'b0;
  logic [9:0]  a_addr = '0;
  logic [1:0]  a_width = '0;
  logic [31:0] a_data = '0;
  logic        b_req = 1'b0, b_sx = 1'b0, b_we = 1'b0, b_lock = 1'b0;
  logic [9:0]  b_addr = '0;
  logic [1:0]  b_width = '0;
  logic [31:0] b_data = '0;
  logic        fp_a_req = 1'b0, fp_b_req = 1'b0;

  logic        a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [31:0] a_rdata, b_rdata;
  logic [9:0]  mem_addr;
  logic [1:0]  mem_width;
  logic        mem_sx, mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;

  logic        fp_a_gnt, fp_a_rvalid, fp_b_gnt, fp_b_rvalid;
  logic [31:0] fp_a_rdata, fp_b_rdata;
  logic [9:0]  fp_mem_addr;
  logic [1:0]  fp_mem_width;
  logic        fp_mem_sx, fp_mem_we;
  logic [31:0] fp_mem_wdata;

  logic        bd_en = 1'b0;
  logic [9:0]  bd_addr = '0;
  logic [7:0]  bd_byte = '0;
  logic [7:0]  mem [0:1023];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    bit          port;
    bit          chk;
    logic [31:0] data;
    int          due;
  } rsp_t;
  rsp_t sbq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  hippo_mem_arbiter #(.MEMORY_DEPTH_BYTES(1024), .FIXED_PRIORITY(0), .LOCK_MAX_CYCLES(8)) u_rr (
    .clk_i(clk), .rst_i(rst),
    .a_req_i(a_req), .a_addr_i(a_addr), .a_width_i(a_width), .a_sign_extend_i(a_sx),
    .a_we_i(a_we), .a_data_i(a_data), .a_gnt_o(a_gnt), .a_rvalid_o(a_rvalid), .a_rdata_o(a_rdata),
    .b_req_i(b_req), .b_addr_i(b_addr), .b_width_i(b_width), .b_sign_extend_i(b_sx),
    .b_we_i(b_we), .b_data_i(b_data), .b_lock_i(b_lock),
    .b_gnt_o(b_gnt), .b_rvalid_o(b_rvalid), .b_rdata_o(b_rdata),
    .mem_addr_o(mem_addr), .mem_width_o(mem_width), .mem_sign_extend_o(mem_sx),
    .mem_data_o(mem_wdata), .mem_we_o(mem_we), .mem_data_i(mem_rdata)
  );

  hippo_mem_arbiter #(.MEMORY_DEPTH_BYTES(1024), .FIXED_PRIORITY(1), .LOCK_MAX_CYCLES(8)) u_fp (
    .clk_i(clk), .rst_i(rst),
    .a_req_i(fp_a_req), .a_addr_i(a_addr), .a_width_i(a_width), .a_sign_extend_i(a_sx),
    .a_we_i(1'b0), .a_data_i(a_data), .a_gnt_o(fp_a_gnt), .a_rvalid_o(fp_a_rvalid), .a_rdata_o(fp_a_rdata),
    .b_req_i(fp_b_req), .b_addr_i(b_addr), .b_width_i(b_width), .b_sign_extend_i(b_sx),
    .b_we_i(1'b0), .b_data_i(b_data), .b_lock_i(1'b0),
    .b_gnt_o(fp_b_gnt), .b_rvalid_o(fp_b_rvalid), .b_rdata_o(fp_b_rdata),
    .mem_addr_o(fp_mem_addr), .mem_width_o(fp_mem_width), .mem_sign_extend_o(fp_mem_sx),
    .mem_data_o(fp_mem_wdata), .mem_we_o(fp_mem_we), .mem_data_i(32'hCAFEF00D)
  );

  // Little-endian byte memory with 1-cycle read latency; width/sign done here.
  function automatic logic [31:0] mem_read(input logic [9:0] ad, input logic [1:0] w, input logic s);
    logic [31:0] r;
    r = {mem[ad + 10'd3], mem[ad + 10'd2], mem[ad + 10'd1], mem[ad]};
    case (w)
      W_BYTE:  r = s ? {{24{r[7]}}, r[7:0]} : {24'h0, r[7:0]};
      W_HALF:  r = s ? {{16{r[15]}}, r[15:0]} : {16'h0, r[15:0]};
      default: r = r;
    endcase
    return r;
  endfunction

  always @(posedge clk) begin
    if (bd_en) begin
      mem[bd_addr] <= bd_byte;
    end else if (mem_we) begin
      for (int k = 0; k < 4; k++) begin
        if (k == 0 || (k == 1 && mem_width != W_BYTE) || (k >= 2 && mem_width == W_WORD))
          mem[mem_addr + 10'(k)] <= mem_wdata[8*k +: 8];
      end
    end
    mem_rdata <= mem_read(mem_addr, mem_width, mem_sx);
  end

  // Response monitor for the round-robin instance.
  always @(negedge clk) begin : monitor
    rsp_t e;
    bit   exp_a, exp_b, exp_chk;
    logic [31:0] exp_d;
    exp_a = 1'b0; exp_b = 1'b0; exp_chk = 1'b0; exp_d = '0;
    while (sbq.size() > 0 && sbq[0].due < cyc) begin
      n_tests++; n_fail++;
      $display("FAIL rsp_missed cyc=%0d port=%0d due=%0d", cyc, sbq[0].port, sbq[0].due);
      void'(sbq.pop_front());
    end
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      e = sbq.pop_front();
      exp_a = (e.port == 1'b0);
      exp_b = (e.port == 1'b1);
      exp_chk = e.chk;
      exp_d = e.data;
    end
    n_tests++;
    if (a_rvalid !== exp_a || b_rvalid !== exp_b) begin
      n_fail++;
      $display("FAIL rsp_rvalid cyc=%0d got a=%0b b=%0b exp a=%0b b=%0b", cyc, a_rvalid, b_rvalid, exp_a, exp_b);
    end
    if (exp_chk) begin
      n_tests++;
      if ((exp_a ? a_rdata : b_rdata) !== exp_d) begin
        n_fail++;
        $display("FAIL rsp_rdata cyc=%0d port=%0s got=%h exp=%h", cyc, exp_a ? "A" : "B",
                 exp_a ? a_rdata : b_rdata, exp_d);
      end
    end
    if (!a_rvalid && a_rdata !== 32'h0) begin
      n_tests++; n_fail++;
      $display("FAIL rsp_idle_rdata_a cyc=%0d got=%h exp=0", cyc, a_rdata);
    end
    if (!b_rvalid && b_rdata !== 32'h0) begin
      n_tests++; n_fail++;
      $display("FAIL rsp_idle_rdata_b cyc=%0d got=%h exp=0", cyc, b_rdata);
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  task automatic set_a(input logic req, input logic [9:0] ad, input logic [1:0] w,
                       input logic sx, input logic we, input logic [31:0] d);
    a_req = req; a_addr = ad; a_width = w; a_sx = sx; a_we = we; a_data = d;
  endtask

  task automatic set_b(input logic req, input logic [9:0] ad, input logic [1:0] w,
                       input logic sx, input logic we, input logic [31:0] d, input logic lk);
    b_req = req; b_addr = ad; b_width = w; b_sx = sx; b_we = we; b_data = d; b_lock = lk;
  endtask

  task automatic idle_all();
    set_a(1'b0, '0, '0, 1'b0, 1'b0, '0);
    set_b(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0);
    fp_a_req = 1'b0; fp_b_req = 1'b0;
  endtask

  task automatic push(input bit port, input bit chk, input logic [31:0] d);
    rsp_t e;
    e.port = port; e.chk = chk; e.data = d; e.due = cyc + 1;
    sbq.push_back(e);
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle_all(); rst = 1'b1;
    next_cycle();
    rst = 1'b0;
  endtask

  // A-only grant leaves B favoured for the next tie.
  task automatic favour_b();
    set_a(1'b1, 10'h10, W_WORD, 1'b0, 1'b0, '0);
    set_b(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0);
    @(negedge clk);
    n_tests++;
    if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin
      n_fail++;
      $display("FAIL setup_gnt got a=%0b b=%0b exp a=1 b=0", a_gnt, b_gnt);
    end
    push(1'b0, 1'b1, 32'hDEADBEEF);
    next_cycle();
  endtask

  task automatic preload();
    logic [7:0] bytes [8];
    bytes = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h78, 8'h56, 8'h34, 8'h12};
    for (int i = 0; i < 8; i++) begin
      bd_en = 1'b1;
      bd_addr = (i < 4) ? 10'(16 + i) : 10'(32 + i - 4);
      bd_byte = bytes[i];
      next_cycle();
    end
    bd_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_a(1'b1, 10'h10, W_WORD, 1'b0, 1'b1, 32'h1);
    set_b(1'b1, 10'h20, W_WORD, 1'b0, 1'b1, 32'h2, 1'b1);
    fp_a_req = 1'b1; fp_b_req = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_tests++;
      if (a_gnt !== 1'b0 || b_gnt !== 1'b0 || mem_we !== 1'b0 || fp_a_gnt !== 1'b0 || fp_b_gnt !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_gnt i=%0d got a=%0b b=%0b we=%0b fa=%0b fb=%0b exp all 0",
                 i, a_gnt, b_gnt, mem_we, fp_a_gnt, fp_b_gnt);
      end
      next_cycle();
    end
    idle_all(); rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (mem_addr !== 10'h0 || mem_width !== 2'h0 || mem_wdata !== 32'h0 || mem_we !== 1'b0 || mem_sx !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle_mem got addr=%h w=%0d d=%h we=%0b sx=%0b exp all 0",
               mem_addr, mem_width, mem_wdata, mem_we, mem_sx);
    end
    n_tests++;
    if (fp_a_rvalid !== 1'b0 || fp_b_rvalid !== 1'b0 || fp_a_rdata !== 32'h0 || fp_b_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_fp_rsp got av=%0b bv=%0b exp 0", fp_a_rvalid, fp_b_rvalid);
    end
    next_cycle();
  endtask

  task automatic test_single_read();
    set_a(1'b1, 10'h10, W_WORD, 1'b0, 1'b0, '0);
    @(negedge clk);
    n_tests++;
    if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin
      n_fail++;
      $display("FAIL single_gnt got a=%0b b=%0b exp a=1 b=0", a_gnt, b_gnt);
    end
    n_tests++;
    if (mem_addr !== 10'h10 || mem_width !== W_WORD || mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL single_mem got addr=%h w=%0d we=%0b exp addr=010 w=2 we=0", mem_addr, mem_width, mem_we);
    end
    push(1'b0, 1'b1, 32'hDEADBEEF);
    next_cycle();
    idle_all();
    next_cycle();
  endtask

  task automatic test_round_robin();
    do_reset();
    set_a(1'b1, 10'h10, W_WORD, 1'b0, 1'b0, '0);
    set_b(1'b1, 10'h20, W_WORD, 1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      bit ea;
      ea = (i % 2 == 0);
      @(negedge clk);
      n_tests++;
      if (a_gnt !== ea || b_gnt !== !ea) begin
        n_fail++;
        $display("FAIL rr_gnt i=%0d got a=%0b b=%0b exp a=%0b b=%0b", i, a_gnt, b_gnt, ea, !ea);
      end
      n_tests++;
      if (mem_addr !== (ea ? 10'h10 : 10'h20)) begin
        n_fail++;
        $display("FAIL rr_addr i=%0d got=%h exp=%h", i, mem_addr, ea ? 10'h10 : 10'h20);
      end
      push(!ea, 1'b1, ea ? 32'hDEADBEEF : 32'h12345678);
      next_cycle();
    end
    idle_all();
    next_cycle();
  endtask

  task automatic test_fixed_priority();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      bit eag, ebg, eav, ebv;
      fp_a_req = (i < 5);
      fp_b_req = (i < 4);
      eag = (i == 4); ebg = (i < 4);
      eav = (i == 5); ebv = (i >= 1 && i <= 4);
      @(negedge clk);
      n_tests++;
      if (fp_a_gnt !== eag || fp_b_gnt !== ebg) begin
        n_fail++;
        $display("FAIL fp_gnt i=%0d got a=%0b b=%0b exp a=%0b b=%0b", i, fp_a_gnt, fp_b_gnt, eag, ebg);
      end
      n_tests++;
      if (fp_a_rvalid !== eav || fp_b_rvalid !== ebv) begin
        n_fail++;
        $display("FAIL fp_rvalid i=%0d got a=%0b b=%0b exp a=%0b b=%0b", i, fp_a_rvalid, fp_b_rvalid, eav, ebv);
      end
      if (eav || ebv) begin
        n_tests++;
        if ((eav ? fp_a_rdata : fp_b_rdata) !== 32'hCAFEF00D) begin
          n_fail++;
          $display("FAIL fp_rdata i=%0d got=%h exp=cafef00d", i, eav ? fp_a_rdata : fp_b_rdata);
        end
      end
      next_cycle();
    end
    idle_all();
  endtask

  task automatic test_lock_rmw();
    do_reset();
    favour_b();
    for (int i = 0; i < 5; i++) begin
      bit ea;
      case (i)
        0: begin set_a(1'b1, 10'h10, W_WORD, 1'b0, 1'b0, '0);
                 set_b(1'b1, 10'h3, W_BYTE, 1'b0, 1'b1, 32'h5A, 1'b1); end
        1:       set_b(1'b1, 10'h3, W_BYTE, 1'b0, 1'b0, '0, 1'b1);
        2:       set_b(1'b1, 10'h4, W_BYTE, 1'b0, 1'b1, 32'hA5, 1'b0);
        3:       set_b(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0);
        default: set_a(1'b1, 10'h3, W_HALF, 1'b1, 1'b0, '0);
      endcase
      ea = (i >= 3);
      @(negedge clk);
      n_tests++;
      if (a_gnt !== ea || b_gnt !== !ea) begin
        n_fail++;
        $display("FAIL lock_gnt i=%0d got a=%0b b=%0b exp a=%0b b=%0b", i, a_gnt, b_gnt, ea, !ea);
      end
      case (i)
        0, 2:    push(1'b1, 1'b0, '0);
        1:       push(1'b1, 1'b1, 32'h0000005A);
        3:       push(1'b0, 1'b1, 32'hDEADBEEF);
        default: push(1'b0, 1'b1, 32'hFFFFA55A);
      endcase
      next_cycle();
    end
    idle_all();
    next_cycle();
  endtask

  task automatic test_lock_max();
    do_reset();
    favour_b();
    set_a(1'b1, 10'h10, W_WORD, 1'b0, 1'b0, '0);
    set_b(1'b1, 10'h20, W_WORD, 1'b0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      bit ea;
      ea = (i == 8);
      @(negedge clk);
      n_tests++;
      if (a_gnt !== ea || b_gnt !== !ea) begin
        n_fail++;
        $display("FAIL lockmax_gnt i=%0d got a=%0b b=%0b exp a=%0b b=%0b", i, a_gnt, b_gnt, ea, !ea);
      end
      push(!ea, 1'b1, ea ? 32'hDEADBEEF : 32'h12345678);
      next_cycle();
    end
    idle_all();
    next_cycle();
    set_a(1'b1, 10'h10, W_WORD, 1'b0, 1'b0, '0);
    @(negedge clk);
    n_tests++;
    if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin
      n_fail++;
      $display("FAIL lockmax_release got a=%0b b=%0b exp a=1 b=0", a_gnt, b_gnt);
    end
    push(1'b0, 1'b1, 32'hDEADBEEF);
    next_cycle();
    idle_all();
    next_cycle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_a(1'b1, 10'h10, W_WORD, 1'b0, 1'b0, '0);
    @(negedge clk);
    n_tests++;
    if (a_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_pre_gnt got a=%0b exp 1", a_gnt);
    end
    next_cycle();
    rst = 1'b1;
    set_b(1'b1, 10'h20, W_WORD, 1'b0, 1'b0, '0, 1'b0);
    @(negedge clk);
    n_tests++;
    if (a_gnt !== 1'b0 || b_gnt !== 1'b0 || a_rvalid !== 1'b0 || b_rvalid !== 1'b0 || mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_arb got gnt a=%0b b=%0b rv a=%0b b=%0b exp all 0", a_gnt, b_gnt, a_rvalid, b_rvalid);
    end
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_after_arb got a=%0b b=%0b exp a=1 b=0", a_gnt, b_gnt);
    end
    push(1'b0, 1'b1, 32'hDEADBEEF);
    next_cycle();
    idle_all();
    next_cycle();

    favour_b();
    set_a(1'b1, 10'h10, W_WORD, 1'b0, 1'b0, '0);
    set_b(1'b1, 10'h20, W_WORD, 1'b0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_tests++;
      if (a_gnt !== 1'b0 || b_gnt !== 1'b1) begin
        n_fail++;
        $display("FAIL rstmid_lock_gnt i=%0d got a=%0b b=%0b exp a=0 b=1", i, a_gnt, b_gnt);
      end
      if (i == 0) push(1'b1, 1'b1, 32'h12345678);
      next_cycle();
    end
    rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if (a_gnt !== 1'b0 || b_gnt !== 1'b0 || a_rvalid !== 1'b0 || b_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_lock got gnt a=%0b b=%0b rv a=%0b b=%0b exp all 0", a_gnt, b_gnt, a_rvalid, b_rvalid);
    end
    next_cycle();
    rst = 1'b0;
    b_lock = 1'b0;
    @(negedge clk);
    n_tests++;
    if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_lock_after got a=%0b b=%0b exp a=1 b=0", a_gnt, b_gnt);
    end
    push(1'b0, 1'b1, 32'hDEADBEEF);
    next_cycle();
    idle_all();
    next_cycle();
  endtask

  initial begin
    idle_all();
    rst = 1'b1;
    #1;
    preload();
    test_reset();
    test_single_read();
    test_round_robin();
    test_fixed_priority();
    test_lock_rmw();
    test_lock_max();
    test_reset_mid();
    next_cycle();
    n_tests++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got=%0d pending exp=0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
